// File: rtl/blinky_multi.sv
// Multi-channel LED blinker: per-channel period, on-time and enable, set through a shadowed
// valid/ready config port. Optional breathe mode is built only when BLINKY_BREATHE_EN is defined.
module blinky_multi #(
  parameter int  CHANNELS   = 4,
  parameter int  CNT_W      = 28,
  parameter int  DEF_PERIOD = 125000000,
  parameter int  DEF_ON     = 12500000,
  localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_chan,
  input  logic [CNT_W-1:0]    cfg_period,
  input  logic [CNT_W-1:0]    cfg_on,
  input  logic                cfg_enable,
  input  logic                cfg_breathe,
  input  logic                sync_start,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] cycle_done
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] RST_PER   = CNT_W'(DEF_PERIOD);
  localparam logic [CNT_W-1:0] RST_ON    = CNT_W'(DEF_ON);

  logic [CHANNELS-1:0] pend_all_s;

  // Ready reflects only the addressed channel; out-of-range channels are always writable.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      cfg_ready = (cfg_chan == CH_W'(i)) ? ~pend_all_s[i] : cfg_ready;
    end
  end

`ifdef BLINKY_BREATHE_EN
  logic [7:0] pwm_cnt_q;
  logic [7:0] pwm_cnt_d;

  // Shared free-running PWM ramp for breathe brightness.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + 8'd1;
  end

  // PWM ramp register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= 8'd0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
    end
  end
`else
  logic unused_breathe;
  assign unused_breathe = cfg_breathe;
`endif

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] on_q, on_d;
    logic [CNT_W-1:0] sh_period_q, sh_period_d;
    logic [CNT_W-1:0] sh_on_q, sh_on_d;
    logic             en_q, en_d;
    logic             sh_en_q, sh_en_d;
    logic             pend_q, pend_d;
    logic             led_q, led_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] last_s;
    logic             wrap_s;
    logic             apply_s;
    logic             accept_s;
    logic             on_phase_s;

    // A zero period behaves as a one-cycle period, so the last count is 0.
    assign last_s     = (period_q == CNT_ZERO) ? CNT_ZERO : (period_q - CNT_ONE);
    assign wrap_s     = en_q && (count_q == last_s);
    assign apply_s    = pend_q && (wrap_s || !en_q || sync_start);
    assign accept_s   = cfg_valid && !pend_q && (cfg_chan == CH_W'(g));
    assign on_phase_s = en_q && (count_q < on_q);

`ifdef BLINKY_BREATHE_EN
    logic       brth_q, brth_d;
    logic       sh_brth_q, sh_brth_d;
    logic [7:0] lvl_q, lvl_d;
    logic       up_q, up_d;

    // Triangle brightness level, one step per wrap while breathing.
    always_comb begin
      lvl_d = lvl_q;
      up_d  = up_q;
      if (brth_q && wrap_s) begin
        if (up_q) begin
          if (lvl_q == 8'd255) begin
            lvl_d = 8'd254;
            up_d  = 1'b0;
          end else begin
            lvl_d = lvl_q + 8'd1;
          end
        end else begin
          if (lvl_q == 8'd0) begin
            lvl_d = 8'd1;
            up_d  = 1'b1;
          end else begin
            lvl_d = lvl_q - 8'd1;
          end
        end
      end else begin
        lvl_d = lvl_q;
      end
    end

    // Breathe bit follows the same shadow/apply path as the other settings.
    always_comb begin
      brth_d    = brth_q;
      sh_brth_d = sh_brth_q;
      if (apply_s) begin
        brth_d = sh_brth_q;
      end else if (accept_s) begin
        sh_brth_d = cfg_breathe;
      end else begin
        brth_d = brth_q;
      end
    end

    // Breathe state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        brth_q    <= 1'b0;
        sh_brth_q <= 1'b0;
        lvl_q     <= 8'd0;
        up_q      <= 1'b1;
      end else begin
        brth_q    <= brth_d;
        sh_brth_q <= sh_brth_d;
        lvl_q     <= lvl_d;
        up_q      <= up_d;
      end
    end
`endif

    // Counter, shadow/apply handshake and registered outputs.
    always_comb begin
      count_d     = count_q;
      period_d    = period_q;
      on_d        = on_q;
      en_d        = en_q;
      sh_period_d = sh_period_q;
      sh_on_d     = sh_on_q;
      sh_en_d     = sh_en_q;
      pend_d      = pend_q;
      if (sync_start || !en_q || wrap_s) begin
        count_d = CNT_ZERO;
      end else begin
        count_d = count_q + CNT_ONE;
      end
      // apply needs pend set and accept needs it clear, so they never coincide.
      if (apply_s) begin
        period_d = sh_period_q;
        on_d     = sh_on_q;
        en_d     = sh_en_q;
        pend_d   = 1'b0;
      end else if (accept_s) begin
        sh_period_d = cfg_period;
        sh_on_d     = cfg_on;
        sh_en_d     = cfg_enable;
        pend_d      = 1'b1;
      end else begin
        pend_d = pend_q;
      end
`ifdef BLINKY_BREATHE_EN
      if (brth_q) begin
        led_d = on_phase_s && (pwm_cnt_q < lvl_q);
      end else begin
        led_d = on_phase_s;
      end
`else
      led_d = on_phase_s;
`endif
      done_d = wrap_s && !sync_start;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        count_q     <= CNT_ZERO;
        period_q    <= RST_PER;
        on_q        <= RST_ON;
        en_q        <= 1'b1;
        sh_period_q <= RST_PER;
        sh_on_q     <= RST_ON;
        sh_en_q     <= 1'b1;
        pend_q      <= 1'b0;
        led_q       <= 1'b0;
        done_q      <= 1'b0;
      end else begin
        count_q     <= count_d;
        period_q    <= period_d;
        on_q        <= on_d;
        en_q        <= en_d;
        sh_period_q <= sh_period_d;
        sh_on_q     <= sh_on_d;
        sh_en_q     <= sh_en_d;
        pend_q      <= pend_d;
        led_q       <= led_d;
        done_q      <= done_d;
      end
    end

    assign pend_all_s[g] = pend_q;
    assign led[g]        = led_q;
    assign cycle_done[g] = done_q;
  end

endmodule

// File: tb/tb_blinky_multi.sv
// Directed bench for blinky_multi (CHANNELS=2, CNT_W=8, 10/1 defaults) plus a CHANNELS=3
// instance used for the out-of-range channel write.
module tb_blinky_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid, cfg_enable, cfg_breathe, sync_start;
  logic       cfg_chan;
  logic [7:0] cfg_period, cfg_on;
  logic       cfg_ready;
  logic [1:0] led, cycle_done;

  logic       cfg3_valid, cfg3_ready;
  logic [1:0] cfg3_chan;
  logic [7:0] cfg3_period, cfg3_on;
  logic       cfg3_enable;
  logic [2:0] led3, done3;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  blinky_multi #(.CHANNELS(2), .CNT_W(8), .DEF_PERIOD(10), .DEF_ON(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_chan(cfg_chan), .cfg_period(cfg_period), .cfg_on(cfg_on),
    .cfg_enable(cfg_enable), .cfg_breathe(cfg_breathe), .sync_start(sync_start),
    .led(led), .cycle_done(cycle_done)
  );

  blinky_multi #(.CHANNELS(3), .CNT_W(8), .DEF_PERIOD(10), .DEF_ON(1)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg3_valid), .cfg_ready(cfg3_ready),
    .cfg_chan(cfg3_chan), .cfg_period(cfg3_period), .cfg_on(cfg3_on),
    .cfg_enable(cfg3_enable), .cfg_breathe(1'b0), .sync_start(1'b0),
    .led(led3), .cycle_done(done3)
  );

  typedef struct {
    logic       v;
    logic       ch;
    logic [7:0] p;
    logic [7:0] on;
    logic       en;
    logic       rdy;
    logic [1:0] led;
    logic [1:0] done;
  } vec_t;

  vec_t tbl[22];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cfg_valid  = 1'b0;
    sync_start = 1'b0;
  endtask

  task automatic cyc(input string nm, input logic [1:0] el, input logic [1:0] ed);
    tick();
    check({nm, "_led"}, {6'd0, led}, {6'd0, el});
    check({nm, "_done"}, {6'd0, cycle_done}, {6'd0, ed});
  endtask

  task automatic set_cfg(input logic ch, input logic [7:0] p, input logic [7:0] on, input logic en);
    cfg_valid  = 1'b1;
    cfg_chan   = ch;
    cfg_period = p;
    cfg_on     = on;
    cfg_enable = en;
    #1;
    check("cfg_ready_write", {7'd0, cfg_ready}, 8'd1);
  endtask

  task automatic do_sync(input string nm);
    sync_start = 1'b1;
    tick();
    check({nm, "_sync_done"}, {6'd0, cycle_done}, 8'd0);
  endtask

  initial begin
    // Edges 21..42: ch1 reprogrammed to 4/2 at edge 22, rejected retry at 25, applied at wrap 30.
    tbl[0]  = '{1'b0, 1'b0, 8'd0, 8'd0, 1'b1, 1'b1, 2'b11, 2'b00};
    tbl[1]  = '{1'b1, 1'b1, 8'd4, 8'd2, 1'b1, 1'b1, 2'b00, 2'b00};
    tbl[2]  = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[3]  = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[4]  = '{1'b1, 1'b1, 8'd6, 8'd3, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[5]  = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[6]  = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[7]  = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[8]  = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 2'b00, 2'b00};
    tbl[9]  = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b0, 2'b00, 2'b11};
    tbl[10] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b11, 2'b00};
    tbl[11] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b10, 2'b00};
    tbl[12] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b00, 2'b00};
    tbl[13] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b00, 2'b10};
    tbl[14] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b10, 2'b00};
    tbl[15] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b10, 2'b00};
    tbl[16] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b00, 2'b00};
    tbl[17] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b00, 2'b10};
    tbl[18] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b10, 2'b00};
    tbl[19] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b10, 2'b01};
    tbl[20] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b01, 2'b00};
    tbl[21] = '{1'b0, 1'b1, 8'd0, 8'd0, 1'b1, 1'b1, 2'b00, 2'b10};

    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_chan = 1'b1; cfg_period = 8'd0; cfg_on = 8'd0;
    cfg_enable = 1'b1; cfg_breathe = 1'b0; sync_start = 1'b0;
    cfg3_valid = 1'b0; cfg3_chan = 2'd3; cfg3_period = 8'd1; cfg3_on = 8'd0; cfg3_enable = 1'b0;
    #1;
    check("rst_led", {6'd0, led}, 8'd0);
    check("rst_done", {6'd0, cycle_done}, 8'd0);
    check("rst_ready", {7'd0, cfg_ready}, 8'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_held_led", {6'd0, led}, 8'd0);
    rst_n = 1'b1;

    // Defaults: on for one edge, off for nine; CHANNELS=3 instance ignores a chan-3 write.
    for (int k = 1; k <= 20; k++) begin
      logic [1:0] el, ed;
      if (k == 5) begin
        cfg3_valid = 1'b1;
        #1;
        check("ch3_ready", {7'd0, cfg3_ready}, 8'd1);
      end
      @(posedge clk);
      #1;
      cfg3_valid = 1'b0;
      el = ((k - 1) % 10 == 0) ? 2'b11 : 2'b00;
      ed = (k % 10 == 0) ? 2'b11 : 2'b00;
      check($sformatf("def%0d_led", k), {6'd0, led}, {6'd0, el});
      check($sformatf("def%0d_done", k), {6'd0, cycle_done}, {6'd0, ed});
      check($sformatf("ch3x%0d_led", k), {5'd0, led3}, {5'd0, {el[0], el}});
      check($sformatf("ch3x%0d_done", k), {5'd0, done3}, {5'd0, {ed[0], ed}});
    end

    for (int i = 0; i < 22; i++) begin
      cfg_valid  = tbl[i].v;
      cfg_chan   = tbl[i].ch;
      cfg_period = tbl[i].p;
      cfg_on     = tbl[i].on;
      cfg_enable = tbl[i].en;
      #1;
      check($sformatf("row%0d_ready", i), {7'd0, cfg_ready}, {7'd0, tbl[i].rdy});
      @(posedge clk);
      #1;
      cfg_valid = 1'b0;
      check($sformatf("row%0d_led", i), {6'd0, led}, {6'd0, tbl[i].led});
      check($sformatf("row%0d_done", i), {6'd0, cycle_done}, {6'd0, tbl[i].done});
    end

    // ch0 on=0 stuck off, ch1 on=12 > period stuck on, wraps still pulse.
    set_cfg(1'b0, 8'd10, 8'd0, 1'b1);
    tick();
    set_cfg(1'b1, 8'd10, 8'd12, 1'b1);
    tick();
    do_sync("s4a");
    for (int k = 1; k <= 12; k++) begin
      cyc($sformatf("s4a_%0d", k), 2'b10, (k == 10) ? 2'b11 : 2'b00);
    end

    // ch1 period=0 acts as period 1: cycle_done every edge.
    set_cfg(1'b1, 8'd0, 8'd0, 1'b1);
    tick();
    do_sync("s4b");
    for (int k = 1; k <= 3; k++) begin
      cyc($sformatf("s4b_%0d", k), 2'b00, 2'b10);
    end

    // Disable ch0 while on; it drops after its wrap, then re-enable and re-align with sync.
    set_cfg(1'b0, 8'd10, 8'd10, 1'b1);
    tick();
    do_sync("s5");
    cyc("s5_1", 2'b01, 2'b10);
    set_cfg(1'b0, 8'd10, 8'd10, 1'b0);
    cyc("s5_2", 2'b01, 2'b10);
    cfg_chan = 1'b0;
    #1;
    check("s5_pend_ready", {7'd0, cfg_ready}, 8'd0);
    for (int k = 3; k <= 9; k++) begin
      cyc($sformatf("s5_%0d", k), 2'b01, 2'b10);
    end
    cyc("s5_10", 2'b01, 2'b11);
    cyc("s5_11", 2'b00, 2'b10);
    cyc("s5_12", 2'b00, 2'b10);
    set_cfg(1'b0, 8'd10, 8'd10, 1'b1);
    cyc("s5_13", 2'b00, 2'b10);
    cyc("s5_14", 2'b00, 2'b10);
    cyc("s5_15", 2'b01, 2'b10);
    set_cfg(1'b1, 8'd10, 8'd1, 1'b1);
    cyc("s5_16", 2'b01, 2'b10);
    cyc("s5_17", 2'b01, 2'b10);
    cyc("s5_18", 2'b11, 2'b00);
    do_sync("s5s");
    for (int k = 1; k <= 10; k++) begin
      cyc($sformatf("s5s_%0d", k), (k == 1) ? 2'b11 : 2'b01, (k == 10) ? 2'b11 : 2'b00);
    end

    // Reset mid-operation discards a pending write and restores defaults.
    set_cfg(1'b1, 8'd4, 8'd2, 1'b1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_led", {6'd0, led}, 8'd0);
    check("mid_rst_done", {6'd0, cycle_done}, 8'd0);
    check("mid_rst_ready", {7'd0, cfg_ready}, 8'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc("post_rst_1", 2'b11, 2'b00);
    cyc("post_rst_2", 2'b00, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
